// File: rtl/mux_scan_sequencer_if.sv
// Select handshake between the scan sequencer and the mux consumer.
//
// Signals:
//   sel        select value driven to the mux S input
//   sel_valid  sel has settled and is offered to the consumer
//   sel_ready  consumer accepts the current select
//
// Modports:
//   master  the sequencer side (drives sel/sel_valid, observes sel_ready)
//   slave   the consumer side (observes sel/sel_valid, drives sel_ready)
interface mux_scan_sequencer_if #(
    parameter int unsigned SEL_W = 4
) ();

    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             sel_ready;

    modport master (
        output sel,
        output sel_valid,
        input  sel_ready
    );

    modport slave (
        input  sel,
        input  sel_valid,
        output sel_ready
    );

endinterface

// File: rtl/mux_scan_sequencer.sv
// Upstream select generator for the 16-input bus multiplexer.
//
// Walks the enabled channels of a latched channel mask in ascending order. Each enabled
// channel is driven onto sel, held for a programmable settle time, then offered to the
// downstream consumer with a valid/ready handshake. Single-sweep and continuous (wrapping)
// scans are supported; a continuous scan is ended by stop at the end of the current sweep.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       begin a scan (only honoured while idle)
//   stop        end a continuous scan after the current sweep
//   continuous  1 = wrap after the last channel, 0 = single sweep (latched at start)
//   ch_mask     channel enables, bit i = channel i (latched at start)
//   dwell       settle cycles per channel before presenting (latched at start)
//   busy        high whenever a scan is in progress
//   done        one-cycle pulse when a scan ends normally
//   err_empty   one-cycle pulse when start is seen with an all-zero mask
//   sel_if      select handshake (sel, sel_valid out; sel_ready in)
module mux_scan_sequencer #(
    parameter int unsigned N_CH    = 16,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [DWELL_W-1:0]   dwell,
    output logic                 busy,
    output logic                 done,
    output logic                 err_empty,
    mux_scan_sequencer_if.master sel_if
);

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StSettle,
        StPresent
    } state_e;

    localparam logic [SEL_W-1:0]   LastIdx = SEL_W'(N_CH - 1);
    localparam logic [DWELL_W-1:0] CntOne  = DWELL_W'(1);

    state_e             state_q;
    logic               start_pend_q;  // start seen in idle, scan begins next edge
    logic [N_CH-1:0]    mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               cont_q;
    logic               stop_q;
    logic [SEL_W-1:0]   idx_q;
    logic [SEL_W-1:0]   sel_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic idx_last;
    logic idx_hit;
    logic wrap;

    assign idx_last = (idx_q == LastIdx);
    assign idx_hit  = mask_q[idx_q];
    // A stop arriving on the very edge that ends a sweep still counts.
    assign wrap     = cont_q && !(stop_q || stop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            start_pend_q <= 1'b0;
            mask_q       <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            cont_q       <= 1'b0;
            stop_q       <= 1'b0;
            idx_q        <= '0;
            sel_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (busy_q && stop) begin
                stop_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    // Start is taken one edge after it is sampled: configuration is
                    // latched first, then the scan (or the empty-mask error) follows.
                    if (start_pend_q) begin
                        start_pend_q <= 1'b0;
                        if (mask_q == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StSearch;
                        end
                    end else if (start) begin
                        start_pend_q <= 1'b1;
                        mask_q       <= ch_mask;
                        dwell_q      <= dwell;
                        cont_q       <= continuous;
                    end
                end

                StSearch: begin
                    // One index examined per cycle.
                    if (idx_hit) begin
                        sel_q <= idx_q;
                        if (dwell_q == '0) begin
                            valid_q <= 1'b1;
                            state_q <= StPresent;
                        end else begin
                            cnt_q   <= dwell_q;
                            state_q <= StSettle;
                        end
                    end else if (!idx_last) begin
                        idx_q <= idx_q + 1'b1;
                    end else if (wrap) begin
                        idx_q <= '0;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        stop_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                StSettle: begin
                    // Exactly dwell cycles spent here, leaving when the count reaches one.
                    if (cnt_q == CntOne) begin
                        valid_q <= 1'b1;
                        state_q <= StPresent;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StPresent: begin
                    if (valid_q && sel_if.sel_ready) begin
                        valid_q <= 1'b0;
                        if (!idx_last) begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StSearch;
                        end else if (wrap) begin
                            idx_q   <= '0;
                            state_q <= StSearch;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            stop_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sel_if.sel       = sel_q;
    assign sel_if.sel_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_empty        = err_q;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream select generator for the 16-input bus multiplexer. Produces the 4-bit channel select.
- Steps through the enabled channels in ascending order. Holds each select for a programmable settle time, then presents it to the downstream consumer with a valid/ready handshake.
- Supports single-sweep and continuous (wrapping) scan modes.

Parameters:
- N_CH, 16, number of mux channels; must equal 2**SEL_W.
- SEL_W, 4, width of the select output.
- DWELL_W, 8, width of the settle-time count.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  in continuous mode, ends the scan at the end of the current sweep.
- continuous  input  1  1 = wrap after the last channel; 0 = single sweep. Latched at start.
- ch_mask  input  N_CH  channel enable, bit i = channel i. Latched at start.
- dwell  input  DWELL_W  settle cycles per channel before presenting. Latched at start.
- sel_ready  input  1  downstream accepts the current select.
- sel  output  SEL_W  mux select (drives mux S).
- sel_valid  output  1  sel settled and offered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a scan ends normally.
- err_empty  output  1  one-cycle pulse when start is sampled with ch_mask == 0.

Behaviour:
- Reset values (rst high at an edge): state IDLE, sel = 0, sel_valid = 0, busy = 0, done = 0, err_empty = 0, idx = 0, stop latch cleared.
  - Reset mid-scan aborts immediately; done is not pulsed.
- States: IDLE, SEARCH, SETTLE, PRESENT.
- IDLE, start = 1:
  - If ch_mask == 0: err_empty pulses next cycle; stay in IDLE.
  - Otherwise: latch mask, dwell and continuous; idx = 0; go to SEARCH.
  - start is ignored while busy.
- SEARCH: examines one index per cycle.
  - mask_q[idx] = 1: sel <= idx. Go to SETTLE with cnt = dwell, or straight to PRESENT if dwell = 0.
  - mask_q[idx] = 0 and idx < N_CH-1: idx++.
  - mask_q[idx] = 0 and idx = N_CH-1: end-of-sweep.
- SETTLE: occupies exactly dwell cycles (cnt decrements; leave when cnt = 1); sel_valid = 0.
- PRESENT: sel_valid = 1 and sel held stable until sel_valid && sel_ready.
  - On handshake: sel_valid drops next cycle. If idx < N_CH-1: idx++, go to SEARCH; else end-of-sweep.
  - sel_ready = 1 held permanently gives a one-cycle PRESENT per channel.
- End-of-sweep:
  - continuous = 1 and no stop latched: idx = 0, SEARCH.
  - Otherwise: done pulses 1 cycle, go to IDLE.
  - sel keeps its last value in IDLE.
- stop: latched while busy; cleared on entry to IDLE. Has no effect in single-sweep mode.
- Timing: with start sampled at edge E0:
  - SEARCH is entered at E1.
  - The first enabled channel k drives sel at edge E(2+k).
  - sel_valid rises at E(2+k+dwell).
- sel changes only on the SEARCH -> SETTLE/PRESENT transition. It never changes while sel_valid = 1.
- dwell = max (255): full count, no overflow. Counter width = DWELL_W.
- sel_ready asserted outside PRESENT is ignored.

Test Plan:
- Single sweep: mask = 16'h0005, dwell = 2, sel_ready = 1, start at E0 -> sel = 0 at E2, sel_valid E4-E5; sel = 2 from E7, sel_valid E9-E10; end-of-sweep at idx 15, done pulse once, busy low after.
- Back-pressure: mask = 16'h8000, dwell = 0, sel_ready low 5 cycles then high -> sel = 15, sel_valid held high and sel stable all 5 cycles; one handshake, then done.
- Continuous + stop: mask = 16'h0003, dwell = 1, continuous = 1, sel_ready = 1; stop pulsed during the 2nd sweep -> sel sequence 0, 1, 0, 1; done after the 2nd sweep; no 3rd sweep.
- Empty mask: start with mask = 0 -> err_empty one pulse, busy stays 0, sel_valid stays 0; start during busy -> ignored, sequence unchanged.
- Reset mid-operation: assert rst during SETTLE of channel 2 -> next edge sel = 0, sel_valid = 0, busy = 0, done = 0; a new start runs from idx 0.
- Full mask: mask = 16'hFFFF, dwell = 0, sel_ready = 1 -> sel presents 0..15 in order, exactly 16 handshakes, done once.
